// File: rtl/i2c_target.sv
// i2c_target: 7-bit I2C target with oversampled SCL/SDA, byte-wide write and read data ports
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  logic [1:0] scl_s, sda_s;
  logic       scl_h, sda_h;
  logic [2:0] state, cnt;
  logic [7:0] shift;
  logic       rw, ph;
  logic       scl, sda, scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in;
  assign scl      = scl_s[1];
  assign sda      = sda_s[1];
  assign scl_rise = scl & ~scl_h;
  assign scl_fall = ~scl & scl_h;
  assign start    = scl & scl_h & sda_h & ~sda;
  assign stop     = scl & scl_h & ~sda_h & sda;
  assign byte_in  = {shift[6:0], sda};
  // ph splits each ACK slot: 0 = waiting to take/see the ACK bit, 1 = waiting for the edge that ends it
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s    <= 2'b11;
      sda_s    <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
      state    <= S_IDLE;
      cnt      <= 3'd0;
      shift    <= 8'h00;
      rw       <= 1'b0;
      ph       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_s    <= {scl_s[0], scl_i};
      sda_s    <= {sda_s[0], sda_i};
      scl_h    <= scl;
      sda_h    <= sda;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start) begin
        state  <= S_ADDR;
        cnt    <= 3'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == ADDR) begin
                state  <= S_ADDR_ACK;
                busy   <= 1'b1;
                rw     <= byte_in[0];
                tx_req <= byte_in[0];
                ph     <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
            if (!ph) begin
              sda_oe <= 1'b1;
              ph     <= 1'b1;
            end else if (rw) begin
              shift  <= {tx_data[6:0], 1'b0};
              sda_oe <= ~tx_data[7];
              cnt    <= 3'd0;
              state  <= S_RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 3'd0;
              state  <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data  <= byte_in;
              rx_valid <= 1'b1;
              state    <= S_WR_ACK;
              ph       <= 1'b0;
            end
          end
          // MSB was already placed on SDA by the edge that ended the ACK slot
          S_RD_DATA: if (scl_fall) begin
            if (cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= S_RD_ACK;
              ph     <= 1'b0;
            end else begin
              sda_oe <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
              cnt    <= cnt + 3'd1;
            end
          end
          S_RD_ACK: if (!ph && scl_rise) begin
            if (sda) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              tx_req <= 1'b1;
              ph     <= 1'b1;
            end
          end else if (ph && scl_fall) begin
            shift  <= {tx_data[6:0], 1'b0};
            sda_oe <= ~tx_data[7];
            cnt    <= 3'd0;
            state  <= S_RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller with transaction-level model and rx/tx scoreboard
module tb_i2c_target;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic       sda_line;
  assign sda_line = sda_m & ~sda_oe;
  i2c_target #(.ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int passes = 0;
  int tx_seen = 0;
  logic oe_seen = 1'b0;
  logic rx_prev = 1'b0;
  logic tx_prev = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] pl[4];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (rx_valid) begin
        chk("rx_single_pulse", {31'd0, rx_prev}, 0);
        chk("rx_expected", {31'd0, exp_rx.size() != 0}, 1);
        if (exp_rx.size() != 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
      if (tx_req) begin
        chk("tx_single_pulse", {31'd0, tx_prev}, 0);
        tx_seen++;
        tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hEE;
      end
    end
    rx_prev = rx_valid;
    tx_prev = tx_req;
  end
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_x(input logic b, output logic r);
    sda_m = b; w(5);
    scl_m = 1'b1; w(5);
    r = sda_line; w(5);
    scl_m = 1'b0; w(5);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; w(5);
    scl_m = 1'b1; w(5);
    sda_m = 1'b0; w(5);
    scl_m = 1'b0; w(5);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; w(5);
    scl_m = 1'b1; w(5);
    sda_m = 1'b1; w(10);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask
  task automatic recv_byte(output logic [7:0] b, input logic m_ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(1'b1, b[i]);
    bit_x(~m_ack, r);
  endtask
  // Model: the target answers only its own address; writes deliver every full byte, reads consume one tx byte per master ACK plus one
  task automatic do_txn(input logic [6:0] a, input logic rw, input int n);
    logic match, ack;
    logic [7:0] got;
    int tx0;
    match = (a == 7'h50);
    tx0 = tx_seen;
    oe_seen = 1'b0;
    tx_q.delete();
    if (rw && match) for (int k = 0; k < n; k++) tx_q.push_back(pl[k]);
    i2c_start();
    send_byte({a, rw}, ack);
    chk("addr_ack", {31'd0, ack}, {31'd0, match});
    chk("busy_addressed", {31'd0, busy}, {31'd0, match});
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        if (match) exp_rx.push_back(pl[k]);
        send_byte(pl[k], ack);
        chk("data_ack", {31'd0, ack}, {31'd0, match});
      end else begin
        recv_byte(got, k < n - 1);
        chk("rd_byte", {24'd0, got}, match ? {24'd0, pl[k]} : 32'hFF);
      end
    end
    if (rw && match) begin
      chk("busy_after_nack", {31'd0, busy}, 0);
      chk("oe_after_nack", {31'd0, sda_oe}, 0);
    end
    i2c_stop();
    chk("busy_idle", {31'd0, busy}, 0);
    chk("oe_idle", {31'd0, sda_oe}, 0);
    chk("rx_all_seen", exp_rx.size(), 0);
    chk("tx_req_count", tx_seen - tx0, (rw && match) ? n : 0);
    if (!match) chk("never_drove", {31'd0, oe_seen}, 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic ack, r;
    logic [7:0] got;
    int tx0, sel;
    logic [6:0] a;
    w(4);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_tx_req", {31'd0, tx_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    w(10);
    chk("no_false_start", {31'd0, busy | sda_oe}, 0);
    pl[0] = 8'h3C; do_txn(7'h50, 1'b0, 1);
    pl[0] = 8'h11; do_txn(7'h51, 1'b0, 1);
    pl[0] = 8'h96; pl[1] = 8'h5A; do_txn(7'h50, 1'b1, 2);
    // repeated START in the middle of a write data byte
    tx_q.delete(); tx0 = tx_seen;
    i2c_start();
    send_byte(8'hA0, ack); chk("rs_addr_ack", {31'd0, ack}, 1);
    for (int i = 0; i < 4; i++) bit_x(1'($urandom), r);
    tx_q.push_back(8'h77);
    i2c_start();
    send_byte(8'hA1, ack); chk("rs_read_ack", {31'd0, ack}, 1);
    recv_byte(got, 1'b0); chk("rs_rd_byte", {24'd0, got}, 32'h77);
    i2c_stop();
    chk("rs_tx_req_count", tx_seen - tx0, 1);
    // reset while the target is pulling SDA low for an address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(1'(8'hA0 >> i), r);
    sda_m = 1'b1; w(5);
    chk("ack_driving", {31'd0, sda_oe}, 1);
    rst = 1'b1; w(1);
    chk("rst_release_oe", {31'd0, sda_oe}, 0);
    chk("rst_release_busy", {31'd0, busy}, 0);
    w(2); rst = 1'b0; w(5);
    pl[0] = 8'($urandom); do_txn(7'h50, 1'b0, 1);
    // STOP after 5 bits of a data byte
    i2c_start();
    send_byte(8'hA0, ack); chk("stop_addr_ack", {31'd0, ack}, 1);
    for (int i = 0; i < 5; i++) bit_x(1'($urandom), r);
    i2c_stop();
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_oe", {31'd0, sda_oe}, 0);
    for (int t = 0; t < 14; t++) begin
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? 7'h50 : (sel == 2) ? 7'h00 : 7'($urandom);
      for (int k = 0; k < 4; k++) pl[k] = 8'($urandom);
      do_txn(a, 1'($urandom), $urandom_range(1, 3));
    end
    w(10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
